audio_clock_regeneration_receiver: RTL and testbench

Sink-side counterpart of the HDMI Audio Clock Regeneration (ACR) packet generator, per HDMI 1.4b Section 5.3.3 / 7.2.3. It accepts decoded data-island packets and extracts N and CTS from ACR packets (type 0x01), validating them and tracking lock across successive packets. From N/CTS it regenerates a 128·fs clock-enable strobe in the `clk_pixel` domain, using a fractional accumulator. It sits after the packet decoder and feeds the audio sample FIFO / DAC interface.

---
 rtl/hdmi_acr_pkg.sv | 32 +++
 rtl/audio_clock_regeneration_nco.sv | 46 ++++
 rtl/audio_clock_regeneration_receiver.sv | 147 ++++++++++++++
 tb/tb_audio_clock_regeneration_receiver.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_acr_pkg.sv
// Shared HDMI Audio Clock Regeneration definitions: packet type, lock FSM
// encoding and subpacket field positions common to transmitter and receiver.
package hdmi_acr_pkg;

    localparam logic [7:0] ACR_PACKET_TYPE = 8'h01;
    localparam int         ACR_FIELD_W     = 20;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2
    } acr_lock_state_t;

    // Byte lanes inside a 56-bit subpacket (SB0 = [7:0] ... SB6 = [55:48]).
    localparam int CTS_HI_BIT  = 8;
    localparam int CTS_MID_BIT = 16;
    localparam int CTS_LO_BIT  = 24;
    localparam int N_HI_BIT    = 32;
    localparam int N_MID_BIT   = 40;
    localparam int N_LO_BIT    = 48;
    localparam int RSVD_CTS_BIT = 12;
    localparam int RSVD_N_BIT   = 36;

    function automatic logic [ACR_FIELD_W-1:0] acr_cts(input logic [55:0] sp);
        return {sp[CTS_HI_BIT +: 4], sp[CTS_MID_BIT +: 8], sp[CTS_LO_BIT +: 8]};
    endfunction

    function automatic logic [ACR_FIELD_W-1:0] acr_n(input logic [55:0] sp);
        return {sp[N_HI_BIT +: 4], sp[N_MID_BIT +: 8], sp[N_LO_BIT +: 8]};
    endfunction

endpackage

// File: rtl/audio_clock_regeneration_nco.sv
// Fractional N/CTS accumulator producing the 128*fs strobe in the pixel clock
// domain. Held cleared whenever enable is low.
module audio_clock_regeneration_nco
    import hdmi_acr_pkg::*;
(
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [ACR_FIELD_W-1:0] n,
    input  logic [ACR_FIELD_W-1:0] cts,
    output logic                   strobe
);

    logic [20:0] acc_q, acc_d;
    logic [21:0] sum;
    logic        strobe_q, strobe_d;

    // acc stays below CTS + tolerance and N < CTS, so one subtraction suffices.
    always_comb begin
        sum      = {1'b0, acc_q} + {2'b00, n};
        acc_d    = '0;
        strobe_d = 1'b0;
        if (enable) begin
            if (sum >= {2'b00, cts}) begin
                acc_d    = 21'(sum - {2'b00, cts});
                strobe_d = 1'b1;
            end else begin
                acc_d = sum[20:0];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acc_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end

    // Gating with enable kills a strobe already registered on the lock-exit cycle.
    assign strobe = strobe_q & enable;

endmodule

// File: rtl/audio_clock_regeneration_receiver.sv
// Sink-side ACR receiver: validates ACR packets, tracks lock and regenerates
// the 128*fs enable. Optional fs strobe counter: ACR_RECEIVER_FS_STROBE_EN.
module audio_clock_regeneration_receiver
    import hdmi_acr_pkg::*;
#(
    parameter int LOCK_COUNT     = 3,
    parameter int CTS_TOLERANCE  = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   packet_valid,
    input  logic [23:0]            header,
    input  logic [55:0]            sub [3:0],
    output logic [ACR_FIELD_W-1:0] n_value,
    output logic [ACR_FIELD_W-1:0] cts_value,
    output logic                   acr_locked,
    output logic                   packet_error,
    output logic                   clk_audio_enable,
    output logic                   clk_audio_sample_enable,
    output acr_lock_state_t        lock_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    acr_lock_state_t        state_q;
    logic [CW-1:0]          match_cnt_q, match_cnt_d;
    logic [TW-1:0]          timer_q;
    logic [ACR_FIELD_W-1:0] n_q, cts_q, ref_n_q, ref_cts_q;
    logic                   packet_error_q;

    logic [ACR_FIELD_W-1:0] pkt_n, pkt_cts, cts_diff;
    logic is_candidate, subs_match, rsvd_set, values_bad;
    logic acr_accept, acr_reject, consistent, audio_en;

    assign pkt_n   = acr_n(sub[0]);
    assign pkt_cts = acr_cts(sub[0]);

    assign is_candidate = packet_valid && (header[7:0] == ACR_PACKET_TYPE);
    assign subs_match   = (sub[1][55:8] == sub[0][55:8]) &&
                          (sub[2][55:8] == sub[0][55:8]) &&
                          (sub[3][55:8] == sub[0][55:8]);
    assign rsvd_set     = (sub[0][RSVD_CTS_BIT +: 4] != 4'h0) ||
                          (sub[0][RSVD_N_BIT +: 4] != 4'h0);
    assign values_bad   = (pkt_n == '0) || (pkt_cts == '0) || (pkt_n >= pkt_cts);

    assign acr_reject = is_candidate && (!subs_match || rsvd_set || values_bad);
    assign acr_accept = is_candidate && !acr_reject;

    assign cts_diff   = (pkt_cts >= ref_cts_q) ? (pkt_cts - ref_cts_q) : (ref_cts_q - pkt_cts);
    assign consistent = (pkt_n == ref_n_q) && (cts_diff <= ACR_FIELD_W'(CTS_TOLERANCE));
    assign match_cnt_d = match_cnt_q + CW'(1);

    // Accepted packets take priority over timeout expiry in the same cycle.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q        <= UNLOCKED;
            match_cnt_q    <= '0;
            timer_q        <= '0;
            n_q            <= '0;
            cts_q          <= '0;
            ref_n_q        <= '0;
            ref_cts_q      <= '0;
            packet_error_q <= 1'b0;
        end else begin
            packet_error_q <= acr_reject;
            if (acr_accept) begin
                n_q     <= pkt_n;
                cts_q   <= pkt_cts;
                timer_q <= '0;
                unique case (state_q)
                    UNLOCKED: begin
                        state_q     <= (LOCK_COUNT <= 1) ? LOCKED : ACQUIRING;
                        match_cnt_q <= CW'(1);
                        ref_n_q     <= pkt_n;
                        ref_cts_q   <= pkt_cts;
                    end
                    ACQUIRING: begin
                        if (consistent) begin
                            match_cnt_q <= match_cnt_d;
                            if (match_cnt_d >= CW'(LOCK_COUNT)) state_q <= LOCKED;
                        end else begin
                            match_cnt_q <= CW'(1);
                            ref_n_q     <= pkt_n;
                            ref_cts_q   <= pkt_cts;
                        end
                    end
                    LOCKED: begin
                        if (!consistent) begin
                            state_q     <= ACQUIRING;
                            match_cnt_q <= CW'(1);
                            ref_n_q     <= pkt_n;
                            ref_cts_q   <= pkt_cts;
                        end
                    end
                    default: state_q <= UNLOCKED;
                endcase
            end else if (state_q != UNLOCKED) begin
                if (timer_q == TIMER_LAST) begin
                    state_q     <= UNLOCKED;
                    match_cnt_q <= '0;
                    timer_q     <= '0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end
        end
    end

    audio_clock_regeneration_nco u_nco (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .enable    (state_q == LOCKED),
        .n         (n_q),
        .cts       (cts_q),
        .strobe    (audio_en)
    );

`ifdef ACR_RECEIVER_FS_STROBE_EN
    logic [6:0] fs_cnt_q;

    always_ff @(posedge clk_pixel) begin
        if (reset || state_q != LOCKED) begin
            fs_cnt_q <= '0;
        end else if (audio_en) begin
            fs_cnt_q <= fs_cnt_q + 7'd1;
        end
    end

    assign clk_audio_sample_enable = audio_en && (fs_cnt_q == 7'd127);
`else
    assign clk_audio_sample_enable = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{header[23:8], sub[0][7:0], sub[1][7:0], sub[2][7:0], sub[3][7:0]};

    assign n_value          = n_q;
    assign cts_value        = cts_q;
    assign acr_locked       = (state_q == LOCKED);
    assign packet_error     = packet_error_q;
    assign clk_audio_enable = audio_en;
    assign lock_state       = state_q;

endmodule

// File: tb/tb_audio_clock_regeneration_receiver.sv
// Bench for audio_clock_regeneration_receiver: packet responses go through an
// expected queue checked by a monitor; strobe rates come from N/CTS arithmetic.
module tb_audio_clock_regeneration_receiver;
  import hdmi_acr_pkg::*;

  localparam int T   = 10000;
  localparam int LC  = 3;
  localparam int TOL = 2;
  localparam int EW  = 44;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        packet_valid = 1'b0;
  logic [23:0] header = '0;
  logic [55:0] sub [3:0];
  logic [19:0] n_value, cts_value;
  logic        acr_locked, packet_error, clk_audio_enable, clk_audio_sample_enable;
  acr_lock_state_t lock_state;

  audio_clock_regeneration_receiver #(
    .LOCK_COUNT(LC), .CTS_TOLERANCE(TOL), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_pixel(clk), .reset(reset), .packet_valid(packet_valid), .header(header),
    .sub(sub), .n_value(n_value), .cts_value(cts_value), .acr_locked(acr_locked),
    .packet_error(packet_error), .clk_audio_enable(clk_audio_enable),
    .clk_audio_sample_enable(clk_audio_sample_enable), .lock_state(lock_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model
  acr_lock_state_t m_state = UNLOCKED;
  int          m_cnt = 0;
  int          m_last_acc = 0;
  logic [19:0] m_n = '0, m_cts = '0, m_ref_n = '0, m_ref_cts = '0;

  // Lock is lost once T+1 cycles have passed since the last accepted packet.
  function automatic acr_lock_state_t state_at(input int c);
    if (m_state != UNLOCKED && (c - m_last_acc) >= T + 1) return UNLOCKED;
    return m_state;
  endfunction

  function automatic logic [55:0] mk_sub(input logic [19:0] n, input logic [19:0] cts);
    logic [55:0] s;
    s = '0;
    s[7:0]   = 8'($urandom_range(0, 255));
    s[15:8]  = {4'h0, cts[19:16]};
    s[23:16] = cts[15:8];
    s[31:24] = cts[7:0];
    s[39:32] = {4'h0, n[19:16]};
    s[47:40] = n[15:8];
    s[55:48] = n[7:0];
    return s;
  endfunction

  // scoreboard queues
  logic [EW-1:0] exp_q[$];
  int            due_q[$];

  task automatic model_packet(input logic [23:0] hdr, input logic [55:0] s0, input logic [55:0] s1,
                              input logic [55:0] s2, input logic [55:0] s3, input int p);
    logic [19:0] pn, pc;
    logic bad, err, acc, cons;
    acr_lock_state_t disp;
    int d;
    if (state_at(p) != m_state) begin m_state = UNLOCKED; m_cnt = 0; end
    pc  = {s0[11:8], s0[23:16], s0[31:24]};
    pn  = {s0[35:32], s0[47:40], s0[55:48]};
    bad = (s1[55:8] != s0[55:8]) || (s2[55:8] != s0[55:8]) || (s3[55:8] != s0[55:8]) ||
          pn == 0 || pc == 0 || pn >= pc || s0[15:12] != 0 || s0[39:36] != 0;
    err = (hdr[7:0] == 8'h01) && bad;
    acc = (hdr[7:0] == 8'h01) && !bad;
    if (acc) begin
      m_n = pn; m_cts = pc; m_last_acc = p;
      d = int'(pc) - int'(m_ref_cts);
      if (d < 0) d = -d;
      cons = (pn == m_ref_n) && (d <= TOL);
      if (m_state == UNLOCKED || !cons) begin
        if (m_state == LOCKED || m_state == UNLOCKED || !cons) begin
          m_state = (m_state == LOCKED || m_state == ACQUIRING || LC > 1) ? ACQUIRING : LOCKED;
          m_cnt = 1; m_ref_n = pn; m_ref_cts = pc;
        end
      end else if (m_state == ACQUIRING) begin
        m_cnt++;
        if (m_cnt >= LC) m_state = LOCKED;
      end
    end
    disp = acc ? m_state : state_at(p + 1);
    exp_q.push_back({err, m_n, m_cts, disp == LOCKED, disp});
    due_q.push_back(p + 1);
  endtask

  // driver: returns at the negedge of the response cycle
  task automatic send_raw(input logic [23:0] hdr, input logic [55:0] s0, input logic [55:0] s1,
                          input logic [55:0] s2, input logic [55:0] s3);
    @(negedge clk);
    header = hdr; sub[0] = s0; sub[1] = s1; sub[2] = s2; sub[3] = s3;
    packet_valid = 1'b1;
    model_packet(hdr, s0, s1, s2, s3, cyc);
    @(negedge clk);
    packet_valid = 1'b0;
    header = '0;
  endtask

  task automatic send_acr(input logic [7:0] typ, input logic [19:0] n, input logic [19:0] cts);
    logic [55:0] s;
    s = mk_sub(n, cts);
    send_raw({16'($urandom_range(0, 65535)), typ}, s, {s[55:8], 8'($urandom_range(0, 255))},
             {s[55:8], 8'($urandom_range(0, 255))}, {s[55:8], 8'($urandom_range(0, 255))});
  endtask

  // monitor
  int en_count = 0;
  int fs_count = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      if (due_q.size() > 0 && cyc == due_q[0]) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("packet_error", packet_error, e[43]);
        chk("n_value", n_value, e[42:23]);
        chk("cts_value", cts_value, e[22:3]);
        chk("acr_locked", acr_locked, e[2]);
        chk("lock_state", lock_state, e[1:0]);
      end else if (packet_error) begin
        errors++;
        $display("FAIL spurious_packet_error: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (clk_audio_enable) begin
        en_count++;
        if (prev_en) begin
          errors++;
          $display("FAIL strobe_spacing: got back-to-back strobes expected gap (cycle %0d)", cyc);
        end
        if (!acr_locked) begin
          errors++;
          $display("FAIL strobe_unlocked: got strobe while unlocked expected none (cycle %0d)", cyc);
        end
      end
      if (clk_audio_sample_enable) fs_count++;
    end
    prev_en = clk_audio_enable;
  end

  // Called right after the locking packet's response: counts strobes over the next k cycles.
  task automatic rate_check(input string nm, input int k, input int n, input int cts);
    int e0, f0;
    longint exp_en;
    #1;
    e0 = en_count; f0 = fs_count;
    repeat (k) @(negedge clk);
    #1;
    exp_en = (longint'(k) * n) / cts;
    chk({nm, "_enable_count"}, en_count - e0, exp_en);
`ifdef ACR_RECEIVER_FS_STROBE_EN
    chk({nm, "_sample_count"}, fs_count - f0, exp_en / 128);
`else
    chk({nm, "_sample_count"}, fs_count - f0, 0);
`endif
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_n"}, n_value, 0);
    chk({nm, "_cts"}, cts_value, 0);
    chk({nm, "_locked"}, acr_locked, 0);
    chk({nm, "_error"}, packet_error, 0);
    chk({nm, "_enable"}, clk_audio_enable, 0);
    chk({nm, "_sample"}, clk_audio_sample_enable, 0);
    chk({nm, "_state"}, lock_state, UNLOCKED);
  endtask

  initial begin
    logic [55:0] s, sb;
    int la, kind, gap, jit;
    logic [19:0] rn, rc;
    for (int i = 0; i < 4; i++) sub[i] = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // lock and rate
    for (int i = 0; i < 3; i++) begin
      send_acr(8'h01, 20'd6144, 20'd74250);
      if (i < 2) repeat (998) @(negedge clk);
    end
    chk("lock_after_3", acr_locked, 1);
    rate_check("rate_6144", 7425, 6144, 74250);

    // CTS jitter, tolerance boundary, then out-of-tolerance
    send_acr(8'h01, 20'd6144, 20'd74249);
    repeat (20) @(negedge clk);
    send_acr(8'h01, 20'd6144, 20'd74251);
    repeat (20) @(negedge clk);
    send_acr(8'h01, 20'd6144, 20'd74252);
    repeat (20) @(negedge clk);
    send_acr(8'h01, 20'd6144, 20'd74260);
    chk("jitter_exit_state", lock_state, ACQUIRING);

    // relock
    for (int i = 0; i < 3; i++) begin
      send_acr(8'h01, 20'd6144, 20'd74250);
      repeat (10) @(negedge clk);
    end

    // subpacket mismatch in sub[2] byte [31:24]
    s = mk_sub(20'd6144, 20'd74251);
    sb = s;
    sb[31:24] = sb[31:24] ^ 8'h5a;
    send_raw(24'h000001, s, s, sb, s);
    repeat (10) @(negedge clk);

    // N above CTS and N equal to CTS
    send_acr(8'h01, 20'd80000, 20'd74250);
    send_acr(8'h01, 20'd74250, 20'd74250);
    repeat (10) @(negedge clk);

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 11);
      rn = 20'd6144;
      jit = $urandom_range(0, 6);
      rc = 20'(74247 + jit);
      s = mk_sub(rn, rc);
      case (kind)
        0: send_acr(8'($urandom_range(2, 255)), rn, rc);
        1: begin
          sb = s;
          sb[8 * $urandom_range(1, 6) +: 8] ^= 8'($urandom_range(1, 255));
          case ($urandom_range(1, 3))
            1: send_raw(24'h000001, s, sb, s, s);
            2: send_raw(24'h000001, s, s, sb, s);
            default: send_raw(24'h000001, s, s, s, sb);
          endcase
        end
        2: begin
          if ($urandom_range(0, 1) == 1) s[15:12] = 4'($urandom_range(1, 15));
          else s[39:36] = 4'($urandom_range(1, 15));
          send_raw(24'h000001, s, s, s, s);
        end
        3: send_acr(8'h01, ($urandom_range(0, 1) == 1) ? 20'd0 : rn, ($urandom_range(0, 1) == 1) ? 20'd0 : rc);
        4: send_acr(8'h01, 20'(int'(rc) + $urandom_range(0, 100)), rc);
        5: send_acr(8'h01, rn, 20'(74250 + $urandom_range(3, 50)));
        6: send_acr(8'h01, 20'd6272, 20'd82500);
        default: send_acr(8'h01, rn, rc);
      endcase
      gap = $urandom_range(5, 150);
      repeat (gap) @(negedge clk);
    end

    // get locked, then mid-operation reset
    for (int i = 0; i < 5; i++) begin
      if (m_state != LOCKED) begin
        send_acr(8'h01, 20'd6144, 20'd74250);
        repeat (5) @(negedge clk);
      end
    end
    chk("locked_before_reset", acr_locked, 1);
    repeat (300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    m_state = UNLOCKED; m_cnt = 0; m_n = '0; m_cts = '0; m_ref_n = '0; m_ref_cts = '0;
    for (int i = 0; i < 3; i++) begin
      send_acr(8'h01, 20'd6144, 20'd74250);
      repeat (50) @(negedge clk);
    end
    chk("relock_after_reset", acr_locked, 1);

    // N change: unlock, two more matching packets relock
    send_acr(8'h01, 20'd6272, 20'd82500);
    chk("n_change_unlock", acr_locked, 0);
    repeat (100) @(negedge clk);
    send_acr(8'h01, 20'd6272, 20'd82500);
    repeat (100) @(negedge clk);
    send_acr(8'h01, 20'd6272, 20'd82500);
    chk("n_change_relock", acr_locked, 1);
    rate_check("rate_6272", 8250, 6272, 82500);

    // timeout while non-ACR packets keep arriving
    la = m_last_acc;
    while (cyc < la + T - 600) begin
      send_acr(8'h02, 20'd6272, 20'd82500);
      repeat (1500) @(negedge clk);
    end
    while (cyc < la + T) @(negedge clk);
    chk("timeout_before", acr_locked, 1);
    @(negedge clk);
    chk("timeout_after_locked", acr_locked, 0);
    chk("timeout_after_state", lock_state, UNLOCKED);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
